pok_palette_arbiter: RTL and testbench

POK_PALETTE_ARBITER -- requirements
Module: pok_palette_arbiter

---
 rtl/pok_palette_arbiter.sv | 139 +++++++++++++
 tb/tb_pok_palette_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pok_palette_arbiter.sv
// Round-robin arbiter sharing one palette ROM between two sprite requesters, with registered colour results.
// Optional screen fade, compiled in with `define PAL_FADE_EN.
module pok_palette_arbiter #(
    parameter logic [4:0] TRANSP_INDEX = 5'd0,
    parameter logic [3:0] FADE_STEP    = 4'd1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [4:0]  idx0,
    input  logic [4:0]  idx1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [11:0] rgb,
    output logic        transp,
    output logic [4:0]  pal_index,
    input  logic [3:0]  pal_red,
    input  logic [3:0]  pal_green,
    input  logic [3:0]  pal_blue
`ifdef PAL_FADE_EN
    ,
    input  logic        frame_tick,
    input  logic        fade_start,
    input  logic        fade_dir,
    output logic        fade_busy,
    output logic        fade_done
`endif
);

    // ptr == 0 means requester 0 wins a tie
    logic        ptr;
    logic [3:0]  level;
    logic [11:0] rgb_next;

    always_comb begin
        gnt0 = Reset_n && req0 && (!req1 || !ptr);
        gnt1 = Reset_n && req1 && (!req0 || ptr);
        if (gnt0)
            pal_index = idx0;
        else if (gnt1)
            pal_index = idx1;
        else
            pal_index = 5'd0;
    end

`ifdef PAL_FADE_EN
    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} fade_state_t;

    fade_state_t state, state_next;
    logic [3:0]  level_next;
    logic [3:0]  level_down;
    logic [4:0]  level_sum;
    logic [3:0]  level_up;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            level     <= 4'hF;
            fade_done <= 1'b0;
        end else begin
            state     <= state_next;
            level     <= level_next;
            fade_done <= (state != IDLE) && (state_next == IDLE);
        end
    end

    // Saturating steps; reaching the end stop finishes the fade
    always_comb begin
        level_down = (level > FADE_STEP) ? (level - FADE_STEP) : 4'h0;
        level_sum  = {1'b0, level} + {1'b0, FADE_STEP};
        level_up   = (level_sum >= 5'd15) ? 4'hF : level_sum[3:0];
        state_next = state;
        level_next = level;
        case (state)
            IDLE: begin
                if (fade_start)
                    state_next = fade_dir ? FADE_IN : FADE_OUT;
            end
            FADE_OUT: begin
                if (frame_tick) begin
                    level_next = level_down;
                    if (level_down == 4'h0)
                        state_next = IDLE;
                end
            end
            FADE_IN: begin
                if (frame_tick) begin
                    level_next = level_up;
                    if (level_up == 4'hF)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fade_busy = (state == FADE_OUT) || (state == FADE_IN);
    end
`else
    logic [3:0] unused_fade_step;
    assign unused_fade_step = FADE_STEP;
    assign level = 4'hF;
`endif

    // Each channel is darkened by (15 - level), clamped at black
    always_comb begin
        logic [3:0] dim;
        dim = 4'hF - level;
        rgb_next[11:8] = (pal_red   > dim) ? (pal_red   - dim) : 4'h0;
        rgb_next[7:4]  = (pal_green > dim) ? (pal_green - dim) : 4'h0;
        rgb_next[3:0]  = (pal_blue  > dim) ? (pal_blue  - dim) : 4'h0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            ptr     <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rgb     <= 12'h000;
            transp  <= 1'b0;
        end else begin
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            if (gnt0 || gnt1) begin
                rgb    <= rgb_next;
                transp <= (pal_index == TRANSP_INDEX);
            end
            if (gnt0)
                ptr <= 1'b1;
            else if (gnt1)
                ptr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pok_palette_arbiter.sv
// Self-checking bench for pok_palette_arbiter: behavioural model compared every cycle plus directed literal checks.
// Covers the fade feature too when built with `define PAL_FADE_EN.
module tb_pok_palette_arbiter;

    localparam logic [4:0] TI = 5'd0;
    localparam int         FS = 1;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [4:0]  idx0 = 5'd0;
    logic [4:0]  idx1 = 5'd0;
    logic        gnt0, gnt1, rvalid0, rvalid1, transp;
    logic [11:0] rgb;
    logic [4:0]  pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic [11:0] rom [32];

`ifdef PAL_FADE_EN
    logic frame_tick = 1'b0;
    logic fade_start = 1'b0;
    logic fade_dir = 1'b0;
    logic fade_busy, fade_done;
`endif

    assign {pal_red, pal_green, pal_blue} = rom[pal_index];

    pok_palette_arbiter #(.TRANSP_INDEX(TI), .FADE_STEP(4'(FS))) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req0(req0), .req1(req1), .idx0(idx0), .idx1(idx1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rgb(rgb), .transp(transp), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue)
`ifdef PAL_FADE_EN
        , .frame_tick(frame_tick), .fade_start(fade_start), .fade_dir(fade_dir),
        .fade_busy(fade_busy), .fade_done(fade_done)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int done_count = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [11:0] dimmed(input logic [11:0] c, input int lvl);
        logic [11:0] r;
        int d, ch;
        r = 12'h000;
        d = 15 - lvl;
        for (int k = 0; k < 3; k++) begin
            ch = int'((c >> (4 * k)) & 12'hF);
            ch = (ch > d) ? ch - d : 0;
            r = r | (12'(ch) << (4 * k));
        end
        return r;
    endfunction

    // Model state: preferred requester, last results, fade level and mode (0 idle, 1 out, 2 in)
    int          m_ptr = 0;
    bit          m_rv0 = 0, m_rv1 = 0, m_tr = 0, m_done = 0;
    logic [11:0] m_rgb = 12'h000;
    int          m_level = 15;
    int          m_mode = 0;

    always @(negedge Clk) begin
        int want;
        logic [4:0] ei;
        want = -1;
        if (Reset_n) begin
            if (req0 && req1) want = m_ptr;
            else if (req0)    want = 0;
            else if (req1)    want = 1;
        end
        ei = (want == 0) ? idx0 : (want == 1) ? idx1 : 5'd0;

        checkOutput("gnt0", gnt0, (want == 0));
        checkOutput("gnt1", gnt1, (want == 1));
        checkOutput("pal_index", pal_index, ei);
        checkOutput("rvalid0", rvalid0, m_rv0);
        checkOutput("rvalid1", rvalid1, m_rv1);
        checkOutput("rgb", rgb, m_rgb);
        checkOutput("transp", transp, m_tr);
`ifdef PAL_FADE_EN
        checkOutput("fade_busy", fade_busy, (m_mode != 0));
        checkOutput("fade_done", fade_done, m_done);
        if (fade_done === 1'b1) done_count++;
`endif

        if (!Reset_n) begin
            m_ptr = 0; m_rv0 = 0; m_rv1 = 0; m_tr = 0; m_rgb = 12'h000;
            m_level = 15; m_mode = 0; m_done = 0;
        end else begin
            m_rv0 = (want == 0);
            m_rv1 = (want == 1);
            if (want >= 0) begin
                m_rgb = dimmed(rom[ei], m_level);
                m_tr  = (ei == TI);
                m_ptr = 1 - want;
            end
`ifdef PAL_FADE_EN
            m_done = 0;
            if (m_mode == 0) begin
                if (fade_start) m_mode = fade_dir ? 2 : 1;
            end else if (frame_tick) begin
                m_level = (m_mode == 1) ? ((m_level - FS < 0) ? 0 : m_level - FS)
                                        : ((m_level + FS > 15) ? 15 : m_level + FS);
                if ((m_mode == 1 && m_level == 0) || (m_mode == 2 && m_level == 15)) begin
                    m_mode = 0;
                    m_done = 1;
                end
            end
`endif
        end
    end

    task automatic applyStimulus(input bit rn, input bit r0, input bit r1, input logic [4:0] i0, input logic [4:0] i1);
        @(posedge Clk);
        #1;
        Reset_n = rn; req0 = r0; req1 = r1; idx0 = i0; idx1 = i1;
    endtask

`ifdef PAL_FADE_EN
    task automatic fadeCycle(input bit start, input bit dir, input bit tick);
        applyStimulus(1, 1, 0, 5'd9, 5'd0);
        fade_start = start; fade_dir = dir; frame_tick = tick;
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 12'($urandom);
        rom[2] = 12'h148;
        rom[9] = 12'hFFE;

        applyStimulus(0, 1, 1, 5'd3, 5'd4);
        applyStimulus(0, 0, 0, 5'd0, 5'd0);

        // Reset state, then single requester 0 with idx 2
        applyStimulus(1, 1, 0, 5'd2, 5'd0);
        #2;
        checkOutput("reset_rvalid0", rvalid0, 0);
        checkOutput("reset_rgb", rgb, 12'h000);
        checkOutput("reset_transp", transp, 0);
        checkOutput("lit_gnt0", gnt0, 1);
        checkOutput("lit_pal_index", pal_index, 5'd2);
        applyStimulus(1, 0, 0, 5'd0, 5'd0);
        #2;
        checkOutput("lit_rvalid0", rvalid0, 1);
        checkOutput("lit_rvalid1", rvalid1, 0);
        checkOutput("lit_rgb", rgb, 12'h148);
        checkOutput("lit_transp", transp, 0);

        // Both requesting after reset alternate 0,1,0,1
        applyStimulus(0, 0, 0, 5'd0, 5'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, k < 4, k < 4, 5'd3, 5'd4);
            #2;
            if (k < 4) begin
                checkOutput("rr_gnt0", gnt0, (k % 2 == 0));
                checkOutput("rr_gnt1", gnt1, (k % 2 == 1));
            end
            if (k > 0) begin
                checkOutput("rr_rvalid0", rvalid0, ((k - 1) % 2 == 0));
                checkOutput("rr_rvalid1", rvalid1, ((k - 1) % 2 == 1));
            end
        end

        // Transparent index on requester 1
        applyStimulus(1, 0, 1, 5'd0, TI);
        applyStimulus(1, 0, 0, 5'd0, 5'd0);
        #2;
        checkOutput("tr_rvalid1", rvalid1, 1);
        checkOutput("tr_transp", transp, 1);

        // Reset in the cycle after a grant
        applyStimulus(1, 1, 0, 5'd5, 5'd0);
        applyStimulus(0, 0, 0, 5'd0, 5'd0);
        applyStimulus(1, 1, 1, 5'd6, 5'd7);
        #2;
        checkOutput("rst_rvalid0", rvalid0, 0);
        checkOutput("rst_rvalid1", rvalid1, 0);
        checkOutput("rst_rgb", rgb, 12'h000);
        checkOutput("rst_gnt0", gnt0, 1);
        checkOutput("rst_gnt1", gnt1, 0);

        // Random traffic with occasional resets
        repeat (2000) begin
            applyStimulus($urandom_range(0, 49) != 0, 1'($urandom), 1'($urandom),
                          5'($urandom), 5'($urandom));
        end

`ifdef PAL_FADE_EN
        applyStimulus(0, 0, 0, 5'd0, 5'd0);
        done_count = 0;
        fadeCycle(1, 0, 0);
        for (int i = 0; i < 15; i++) fadeCycle(i == 5, 1, 1);
        repeat (3) fadeCycle(0, 0, 0);
        #2;
        checkOutput("fade_out_rgb", rgb, 12'h000);
        checkOutput("fade_out_done", done_count, 1);
        checkOutput("fade_out_busy", fade_busy, 0);
        fadeCycle(1, 1, 0);
        for (int i = 0; i < 15; i++) fadeCycle(i == 3, 0, 1);
        repeat (3) fadeCycle(0, 0, 0);
        #2;
        checkOutput("fade_in_rgb", rgb, 12'hFFE);
        checkOutput("fade_in_done", done_count, 2);
`endif

        applyStimulus(1, 0, 0, 5'd0, 5'd0);
        @(posedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
